// File: rtl/seg_pkg.sv
// seg_pkg: symbol codes and active-low {g,f,e,d,c,b,a} glyph table for the scan driver
package seg_pkg;
  localparam int SYM_W = 6;
  localparam logic [SYM_W-1:0] SYM_A     = 6'd0;
  localparam logic [SYM_W-1:0] SYM_ZERO  = 6'd26;
  localparam logic [SYM_W-1:0] SYM_BLANK = 6'd36;
  localparam logic [SYM_W-1:0] SYM_DASH  = 6'd63;
  localparam logic [6:0] GLYPH [64] = '{
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09,
    7'h4F, 7'h61, 7'h0A, 7'h47, 7'h48, 7'h2B, 7'h23, 7'h0C,
    7'h18, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h63, 7'h55, 7'h09,
    7'h11, 7'h24,
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F,
    7'h3F
  };
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational symbol-code to active-low segment pattern lookup
module seg_glyph_rom import seg_pkg::*; (
  input  logic [SYM_W-1:0] code,
  output logic [6:0]       seg
);
  assign seg = GLYPH[code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered multiplexed 7-seg scan with blank interval; SEG_BLINK_EN adds per-digit blinking
module seg_scan_driver import seg_pkg::*; #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SYM_W*NUM_DIGITS-1:0] sym_in,
  input  logic                        upd,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [6:0]                  seg,
  output logic                        frame_start
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = SYM_W*NUM_DIGITS;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV-1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS-1);
  localparam logic [BW-1:0] BUF_RST = {NUM_DIGITS{SYM_BLANK}};
  typedef enum logic {BLANK, DRIVE} slot_t;
  slot_t state;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [IW-1:0] idx;
  logic [BW-1:0] pend, shad;
  logic wrap, swap, show;
  logic [6:0] glyph;
  assign wrap    = pcnt == P_LAST;
  assign swap    = wrap && idx == I_LAST;
  assign pcnt_nx = wrap ? '0 : pcnt + 1'b1;
  seg_glyph_rom u_rom (
    .code(shad[SYM_W*idx +: SYM_W]),
    .seg (glyph)
  );
`ifdef SEG_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES-1);
  logic [FW-1:0] fcnt;
  logic phase_on;
  // count frames and flip the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (swap) begin
      fcnt     <= fcnt == F_LAST ? '0 : fcnt + 1'b1;
      phase_on <= fcnt == F_LAST ? ~phase_on : phase_on;
    end
  assign show = phase_on || !blink_mask[idx];
`else
  localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign show = 1'b1;
`endif
  // strobes land in pend; at frame end shad takes pend, or sym_in directly if a strobe coincides
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= BUF_RST;
      shad <= BUF_RST;
    end else begin
      if (upd) pend <= sym_in;
      if (swap) shad <= upd ? sym_in : pend;
    end
  // slot FSM and registered pin outputs, one cycle behind pcnt/idx
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt        <= '0;
      idx         <= '0;
      state       <= BLANK;
      anode       <= '1;
      seg         <= '1;
      frame_start <= 1'b0;
    end else begin
      pcnt        <= pcnt_nx;
      idx         <= swap ? '0 : wrap ? idx + 1'b1 : idx;
      state       <= pcnt_nx >= P_BLANK ? DRIVE : BLANK;
      anode       <= state == DRIVE && show ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg         <= state == DRIVE ? glyph : '1;
      frame_start <= swap;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver (blink frames checked when SEG_BLINK_EN is defined)
module tb_seg_scan_driver;
  localparam int ND = 4, SD = 8, BC = 2, BF = 2;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  typedef struct packed {logic [3:0] an; logic [6:0] sg;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, upd = 1'b0;
  logic [23:0] sym_in = '0;
  logic [3:0] blink_mask = 4'b0010;
  logic [3:0] anode;
  logic [6:0] seg;
  logic frame_start;
  exp_t q[$];
  int total = 0, bad = 0, off = 0;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .upd(upd), .blink_mask(blink_mask),
    .anode(anode), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [6:0] g0, g1, g2, g3, input bit boff);
    logic [6:0] g [4];
    g = '{g0, g1, g2, g3};
    for (int s = 0; s < 4; s++)
      q.push_back({(boff && s == 1) ? 4'hF : ~(4'b0001 << s), g[s]});
  endtask

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_start;
    end
    check("wait_frame_start", {10'b0, seen}, 11'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 800 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 11'(q.size()), 11'd0);
  endtask

  // monitor: pop and compare at the first driven cycle of every slot
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n || frame_start) off = 0;
    else off++;
    if (rst_n && off % SD == BC + 1 && q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("slot%0d_an_seg", off / SD), {anode, seg}, e);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_anode", {7'b0, anode}, 11'hF);
    check("rst_seg", {4'b0, seg}, 11'h7F);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    push_frame(7'h08, 7'h79, 7'h10, 7'h3F, 1'b0);
    push_frame(7'h30, 7'h24, 7'h79, 7'h40, BLINK);
    push_frame(7'h09, 7'h09, 7'h09, 7'h09, BLINK);
    push_frame(7'h09, 7'h09, 7'h09, 7'h09, 1'b0);
    push_frame(7'h09, 7'h09, 7'h09, 7'h09, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sym_in = {6'd63, 6'd35, 6'd27, 6'd0};
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    wait_fs();
    repeat (SD*ND - 1) @(negedge clk);
    sym_in = {6'd26, 6'd27, 6'd28, 6'd29};
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    check("fs_after_swap", {10'b0, frame_start}, 11'd1);
    repeat (3) @(negedge clk);
    sym_in = {4{6'd5}};
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    repeat (5) @(negedge clk);
    sym_in = {4{6'd7}};
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    drain();
    wait_fs();
    repeat (5) @(negedge clk);
    check("pre_rst_anode", {7'b0, anode}, 11'hE);
    check("pre_rst_seg", {4'b0, seg}, 11'h09);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_anode", {7'b0, anode}, 11'hF);
    check("mid_rst_seg", {4'b0, seg}, 11'h7F);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
